// File: rtl/fpga_exec_pkg.sv
// fpga_exec_pkg: opcodes, FSM encoding, instruction field layout and unpack helper for fpga_exec
package fpga_exec_pkg;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_ADD = 4'd2,
    OP_OUT = 4'd3,
    OP_JNZ = 4'd4,
    OP_ASSERT = 4'd5,
    OP_HALT = 4'd6
  } op_e;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam int OP_W = 4;
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] tgt;
    logic imm;
    logic [31:0] src;
  } instr_t;
  // word layout MSB first: op, tgt[la], imm, src[w]; fields are returned zero-extended
  function automatic instr_t unpack(input logic [63:0] iw, input int la, input int w);
    instr_t r;
    r.src = 32'(iw & ((64'd1 << w) - 64'd1));
    r.imm = 1'(iw >> w);
    r.tgt = 8'((iw >> (w + 1)) & ((64'd1 << la) - 64'd1));
    r.op = 4'(iw >> (w + 1 + la));
    return r;
  endfunction
endpackage

// File: rtl/fpga_exec_out_fifo.sv
// fpga_exec_out_fifo: synchronous FIFO with valid/ready head, occupancy count and synchronous clear
// ports: clock, resetN (async, active low), clear, push/din (dropped when full), ready, valid/dout (head, 0 when empty), full, count
module fpga_exec_out_fifo #(
  parameter int W = 12,
  parameter int N = 16
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 clear,
  input  logic                 push,
  input  logic [W-1:0]         din,
  input  logic                 ready,
  output logic                 valid,
  output logic [W-1:0]         dout,
  output logic                 full,
  output logic [$clog2(N):0]   count
);
  localparam int A = $clog2(N);
  logic [W-1:0] mem [N];
  logic [A-1:0] rd, wr;
  logic do_push, pop;
  assign valid = count != '0;
  assign full = count == (A+1)'(N);
  assign dout = valid ? mem[rd] : '0;
  assign do_push = push && !full;
  assign pop = valid && ready;
  always_ff @(posedge clock) if (do_push && !clear) mem[wr] <= din;
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (clear) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + A'(1);
      if (pop) rd <= rd + A'(1);
      count <= count + (A+1)'(do_push) - (A+1)'(pop);
    end
  end
endmodule

// File: rtl/fpga_exec.sv
// fpga_exec: register-machine executor running a loadable program, streaming OUT words through a FIFO
// ports: clock, resetN (async, active low), run, codeWrite/codeAddr/codeData (load in IDLE/DONE),
//   outValid/outReady/outData/outCount (output stream), finished/success/steps (status), trace* (debug)
// optional: FPGA_EXEC_TRACE_EN enables per-instruction trace outputs and a simulation print
module fpga_exec
  import fpga_exec_pkg::*;
#(
  parameter int MemoryElementWidth = 12,
  parameter int NLocal = 8,
  parameter int NCode = 32,
  parameter int NOut = 16,
  parameter int MaxSteps = 1000
) (
  input  logic                                         clock,
  input  logic                                         resetN,
  input  logic                                         run,
  input  logic                                         codeWrite,
  input  logic [$clog2(NCode)-1:0]                     codeAddr,
  input  logic [4+$clog2(NLocal)+1+MemoryElementWidth-1:0] codeData,
  output logic                                         outValid,
  input  logic                                         outReady,
  output logic [MemoryElementWidth-1:0]                outData,
  output logic [$clog2(NOut):0]                        outCount,
  output logic                                         finished,
  output logic                                         success,
  output logic [31:0]                                  steps,
  output logic                                         traceValid,
  output logic [$clog2(NCode)-1:0]                     traceIp,
  output logic [3:0]                                   traceOp
);
  localparam int W = MemoryElementWidth;
  localparam int LA = $clog2(NLocal);
  localparam int CA = $clog2(NCode);
  localparam int IW = OP_W + LA + 1 + W;
  logic [IW-1:0] code [NCode];
  logic [W-1:0] lmem [NLocal];
  logic [1:0] state;
  logic [CA-1:0] ip, ip_nxt;
  logic fail, illegal, timeout;
  instr_t ins;
  logic [3:0] op;
  logic [LA-1:0] tgt;
  logic [W-1:0] src, s, lt, wr_val;
  logic idle_like, active, start, term, stall, exec, jump, off_end, limit, stop, to, fail_nxt, full;
  logic unused_bits;
  assign ins = unpack(64'(code[ip]), LA, W);
  assign op = ins.op;
  assign tgt = ins.tgt[LA-1:0];
  assign src = ins.src[W-1:0];
  assign unused_bits = ^{ins.tgt[7:LA], ins.src[31:W], illegal, timeout};
  assign s = ins.imm ? src : lmem[src[LA-1:0]];
  assign lt = lmem[tgt];
  assign wr_val = op == OP_ADD ? lt + s : s;
  assign idle_like = state == IDLE || state == DONE;
  assign active = state == EXEC || state == STALL;
  assign start = idle_like && run;
  // HALT and illegal opcodes end the run without being counted as executed
  assign term = active && op >= 4'(OP_HALT);
  // fullness is the registered count, so a pop in this cycle cannot rescue the OUT
  assign stall = active && op == OP_OUT && full;
  assign exec = active && !term && !stall;
  assign jump = op == OP_JNZ && lt != '0;
  assign ip_nxt = jump ? CA'(s) : ip + CA'(1);
  assign off_end = !jump && ip == CA'(NCode - 1);
  assign limit = steps + 32'd1 == 32'(MaxSteps);
  assign stop = off_end || limit;
  // running off the end is a normal finish even when it coincides with the step limit
  assign to = limit && !off_end;
  assign fail_nxt = fail || (op == OP_ASSERT && lt != s);
  always_ff @(posedge clock) if (codeWrite && idle_like) code[codeAddr] <= codeData;
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      ip <= '0;
      steps <= '0;
      finished <= 1'b0;
      success <= 1'b0;
      fail <= 1'b0;
      illegal <= 1'b0;
      timeout <= 1'b0;
      for (int i = 0; i < NLocal; i++) lmem[i] <= '0;
    end else if (start) begin
      state <= EXEC;
      ip <= '0;
      steps <= '0;
      finished <= 1'b0;
      success <= 1'b0;
      fail <= 1'b0;
      illegal <= 1'b0;
      timeout <= 1'b0;
      for (int i = 0; i < NLocal; i++) lmem[i] <= '0;
    end else if (active) begin
      if (term) begin
        state <= DONE;
        finished <= 1'b1;
        illegal <= op != OP_HALT;
        success <= op == OP_HALT && !fail;
      end else if (stall) begin
        state <= STALL;
      end else begin
        steps <= steps + 32'd1;
        ip <= ip_nxt;
        fail <= fail_nxt;
        if (op == OP_MOV || op == OP_ADD) lmem[tgt] <= wr_val;
        state <= stop ? DONE : EXEC;
        finished <= stop;
        timeout <= to;
        success <= stop && !fail_nxt && !to;
      end
    end
  end
  fpga_exec_out_fifo #(.W(W), .N(NOut)) u_fifo (
    .clock(clock),
    .resetN(resetN),
    .clear(start),
    .push(exec && op == OP_OUT),
    .din(s),
    .ready(outReady),
    .valid(outValid),
    .dout(outData),
    .full(full),
    .count(outCount)
  );
`ifdef FPGA_EXEC_TRACE_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      traceValid <= 1'b0;
      traceIp <= '0;
      traceOp <= '0;
    end else begin
      traceValid <= exec;
      if (exec) begin
        traceIp <= ip;
        traceOp <= op;
      end
    end
  end
`ifndef SYNTHESIS
  always @(posedge clock) if (resetN && exec) $display("trace step=%0d ip=%0d op=%0d", steps, ip, op);
`endif
`else
  assign traceValid = 1'b0;
  assign traceIp = '0;
  assign traceOp = '0;
`endif
endmodule

// File: tb/tb_fpga_exec.sv
// tb_fpga_exec: directed programs checked against an instruction-level interpreter plus literal expectations
module tb_fpga_exec;
  localparam int W = 12, NL = 8, NC = 32, NO = 16, MS = 1000, IW = 20;
  logic clock = 1'b0, resetN = 1'b0, run = 1'b0, codeWrite = 1'b0, outReady = 1'b0;
  logic [4:0] codeAddr = '0;
  logic [IW-1:0] codeData = '0;
  logic outValid, finished, success, traceValid;
  logic [W-1:0] outData;
  logic [4:0] outCount, traceIp;
  logic [31:0] steps;
  logic [3:0] traceOp;
  int total = 0, bad = 0;
  int exp_q[$];
  int exp_steps, exp_ok;
  logic [IW-1:0] prog [NC];

  fpga_exec #(.MemoryElementWidth(W), .NLocal(NL), .NCode(NC), .NOut(NO), .MaxSteps(MS)) dut (
    .clock(clock), .resetN(resetN), .run(run), .codeWrite(codeWrite), .codeAddr(codeAddr),
    .codeData(codeData), .outValid(outValid), .outReady(outReady), .outData(outData),
    .outCount(outCount), .finished(finished), .success(success), .steps(steps),
    .traceValid(traceValid), .traceIp(traceIp), .traceOp(traceOp)
  );

  always #5 clock = ~clock;

  function automatic logic [IW-1:0] enc(int op, int t, int im, int src);
    return {4'(op), 3'(t), 1'(im), 12'(src)};
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // instruction-level interpreter with an unbounded output queue
  task automatic model();
    int l[NL];
    int ip, st, op, t, im, src, sv, nx, fl;
    logic [IW-1:0] w;
    foreach (l[i]) l[i] = 0;
    ip = 0; st = 0; fl = 0;
    exp_q.delete();
    while (1) begin
      w = prog[ip];
      op = int'(w[19:16]); t = int'(w[15:13]); im = int'(w[12]); src = int'(w[11:0]);
      sv = im != 0 ? src : l[src % NL];
      if (op == 6) begin exp_ok = fl == 0 ? 1 : 0; break; end
      if (op > 6) begin exp_ok = 0; break; end
      if (op == 1) l[t] = sv;
      else if (op == 2) l[t] = (l[t] + sv) % 4096;
      else if (op == 3) exp_q.push_back(sv);
      else if (op == 5 && l[t] != sv) fl = 1;
      st++;
      nx = (op == 4 && l[t] != 0) ? sv % NC : ip + 1;
      if (nx == NC) begin exp_ok = fl == 0 ? 1 : 0; break; end
      if (st == MS) begin exp_ok = 0; break; end
      ip = nx;
    end
    exp_steps = st;
  endtask

  // compare process: FIFO flag consistency and every popped word against the model queue
  always @(negedge clock) begin
    if (resetN) begin
      total++;
      if (outValid !== (outCount != 0) || outCount > NO) begin
        bad++;
        $display("FAIL fifo_flags: valid=%0d count=%0d", outValid, outCount);
      end
      if (outValid && outReady) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_word: got %0d expected none", outData);
        end else if (outData !== 12'(exp_q[0])) begin
          bad++;
          $display("FAIL out_word: got %0d expected %0d", outData, exp_q[0]);
          void'(exp_q.pop_front());
        end else void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < NC; i++) prog[i] = enc(6, 0, 0, 0);
  endtask

  task automatic load();
    for (int i = 0; i < NC; i++) begin
      codeWrite = 1'b1; codeAddr = 5'(i); codeData = prog[i];
      tick();
    end
    codeWrite = 1'b0;
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic check_reset(string name);
    check({name, "_valid"}, int'(outValid), 0);
    check({name, "_data"}, int'(outData), 0);
    check({name, "_count"}, int'(outCount), 0);
    check({name, "_finished"}, int'(finished), 0);
    check({name, "_success"}, int'(success), 0);
    check({name, "_steps"}, int'(steps), 0);
    check({name, "_tvalid"}, int'(traceValid), 0);
    check({name, "_tip"}, int'(traceIp), 0);
    check({name, "_top"}, int'(traceOp), 0);
  endtask

  task automatic finish_chk(string name, int lit_steps, int lit_ok);
    int n = 0;
    while (!finished && n < 1200) begin tick(); n++; end
    check({name, "_finished"}, int'(finished), 1);
    check({name, "_steps_model"}, int'(steps), exp_steps);
    check({name, "_steps_lit"}, int'(steps), lit_steps);
    check({name, "_ok_model"}, int'(success), exp_ok);
    check({name, "_ok_lit"}, int'(success), lit_ok);
    n = 0;
    while (outCount != 0 && n < 100) begin tick(); n++; end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #12;
    check_reset("reset");
    tick();
    resetN = 1'b1;
    tick();
    // MOV x3, OUT x3, then HALT
    fill_halt();
    prog[0] = enc(1, 0, 1, 1); prog[1] = enc(1, 1, 1, 2); prog[2] = enc(1, 2, 1, 3);
    prog[3] = enc(3, 0, 0, 0); prog[4] = enc(3, 0, 0, 1); prog[5] = enc(3, 0, 0, 2);
    load(); model();
    check("t1_q_len", exp_q.size(), 3);
    check("t1_q0", exp_q[0], 1); check("t1_q1", exp_q[1], 2); check("t1_q2", exp_q[2], 3);
    outReady = 1'b1;
    start();
    finish_chk("t1", 6, 1);
    // ADD wraps 4095+2 to 1, ASSERT passes
    fill_halt();
    prog[0] = enc(1, 0, 1, 4095); prog[1] = enc(2, 0, 1, 2); prog[2] = enc(3, 0, 0, 0);
    prog[3] = enc(5, 0, 1, 1);
    load(); model();
    check("t2_q0", exp_q[0], 1);
    start();
    finish_chk("t2", 4, 1);
    // same with a failing ASSERT
    prog[3] = enc(5, 0, 1, 5);
    load(); model();
    start();
    finish_chk("t2b", 4, 0);
    // endless JNZ loop hits the step limit
    fill_halt();
    prog[0] = enc(1, 0, 1, 1); prog[1] = enc(4, 0, 1, 1);
    load(); model();
    start();
    finish_chk("t3", 1000, 0);
    // 20 OUTs into a 16-deep FIFO with the consumer stalled
    fill_halt();
    for (int i = 0; i < 20; i++) prog[i] = enc(3, 0, 1, 100 + i);
    outReady = 1'b0;
    load(); model();
    check("t4_q19", exp_q[19], 119);
    start();
    tick(30);
    check("t4_count_full", int'(outCount), 16);
    check("t4_steps_stall", int'(steps), 16);
    check("t4_not_done", int'(finished), 0);
    tick(5);
    check("t4_steps_frozen", int'(steps), 16);
    outReady = 1'b1;
    finish_chk("t4", 20, 1);
    // illegal opcode at ip=2
    fill_halt();
    prog[0] = enc(1, 3, 1, 7); prog[1] = enc(0, 0, 0, 0); prog[2] = enc(9, 0, 0, 0);
    load(); model();
    start();
    finish_chk("t5", 2, 0);
    // rerun shows local memory was cleared
    fill_halt();
    prog[0] = enc(3, 0, 0, 3);
    load(); model();
    check("t5b_q0", exp_q[0], 0);
    start();
    finish_chk("t5b", 1, 1);
    // all NOPs: ip runs off the end of code memory
    for (int i = 0; i < NC; i++) prog[i] = enc(0, 0, 0, 0);
    load(); model();
    start();
    finish_chk("t6", 32, 1);
    // reset asserted while stalled
    fill_halt();
    for (int i = 0; i < 20; i++) prog[i] = enc(3, 0, 1, 200 + i);
    outReady = 1'b0;
    load(); model();
    start();
    tick(30);
    check("t7_stalled", int'(steps), 16);
    #3 resetN = 1'b0;
    #1 check_reset("t7_rst");
    exp_q.delete();
    tick();
    resetN = 1'b1;
    tick();
    model();
    outReady = 1'b1;
    start();
    finish_chk("t7", 20, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
